cw305_pulpino_mailbox_ctrl: RTL and testbench

- Byte-mailbox sequencer between the CW305 host register bank and the PULPino core.
- Sits in the crypto_clk domain. Consumes the host-written data/flags bytes and produces the pulpino-to-host data/flags bytes read back by the host.
- Uses a toggle handshake that is safe across clock domains.
- Presents valid/ready byte streams to the core, with a small TX FIFO so the core can queue bytes toward the host.

---
 rtl/cw305_pulpino_mailbox_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cw305_pulpino_mailbox_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_pulpino_mailbox_ctrl.sv
// Byte-mailbox sequencer between the CW305 host register bank and the PULPino core.
// Runs entirely in crypto_clk. Host flags arrive as toggles and are synchronised
// here; host data is sampled only once its request toggle has crossed the
// synchroniser. Core-side bytes use valid/ready, with a small TX FIFO toward the host.
module cw305_pulpino_mailbox_ctrl #(
    parameter int pFIFO_DEPTH  = 4,
    parameter int pSYNC_STAGES = 2
) (
    input  logic                           crypto_clk,
    input  logic                           reset_i,
    input  logic [7:0]                     I_ext_data,
    input  logic [7:0]                     I_ext_flags,
    output logic [7:0]                     O_pulpino_data,
    output logic [7:0]                     O_pulpino_flags,
    output logic [7:0]                     rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    input  logic [7:0]                     tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [$clog2(pFIFO_DEPTH):0]   tx_level
);

    localparam int PTR_W = $clog2(pFIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(pFIFO_DEPTH);

    typedef enum logic {
        RX_IDLE,
        RX_HOLD
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_t;

    // Synchroniser chains for the two host toggle bits
    logic [pSYNC_STAGES-1:0] req_sync;
    logic [pSYNC_STAGES-1:0] ack_sync;
    logic                    req_s;
    logic                    ack_s;
    logic                    ack_s_q;

    // RX side state
    rx_state_t rx_state;
    logic      rx_ack;

    // TX FIFO state
    logic [7:0]       fifo_mem [pFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_nonempty;

    // TX side handshake state
    tx_state_t tx_state;
    logic      tx_req;
    logic      spurious_err;

    // The upper host flag bits carry no meaning for this block
    logic unused_flag_bits;
    assign unused_flag_bits = ^I_ext_flags[7:2];

    assign req_s = req_sync[pSYNC_STAGES-1];
    assign ack_s = ack_sync[pSYNC_STAGES-1];

    // Shift the host request/ack toggles through their synchroniser chains
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            req_sync <= '0;
            ack_sync <= '0;
        end else begin
            req_sync <= {req_sync[pSYNC_STAGES-2:0], I_ext_flags[0]};
            ack_sync <= {ack_sync[pSYNC_STAGES-2:0], I_ext_flags[1]};
        end
    end

    // RX sequencer: capture a host byte on a new request, hold it until the core takes it
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            rx_state <= RX_IDLE;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ack   <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (req_s != rx_ack) begin
                        rx_data  <= I_ext_data;
                        rx_valid <= 1'b1;
                        rx_state <= RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        rx_ack   <= ~rx_ack;
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // FIFO accepts whenever not full; a pop in the same cycle does not free a slot early
    assign tx_ready = (tx_level != LVL_FULL);
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = (tx_state == TX_WAIT) && (ack_s == tx_req);

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        level_next = tx_level;
        case ({tx_push, tx_pop})
            2'b10:   level_next = tx_level + 1'b1;
            2'b01:   level_next = tx_level - 1'b1;
            default: level_next = tx_level;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge crypto_clk) begin
        if (tx_push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the registered non-empty status bit
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_level    <= '0;
            tx_nonempty <= 1'b0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            tx_level    <= level_next;
            tx_nonempty <= (level_next != '0);
        end
    end

    // TX sequencer: present the FIFO head to the host and retire it once the host acks
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            tx_state       <= TX_IDLE;
            O_pulpino_data <= '0;
            tx_req         <= 1'b0;
            ack_s_q        <= 1'b0;
            spurious_err   <= 1'b0;
        end else begin
            ack_s_q <= ack_s;
            if ((tx_state == TX_IDLE) && (ack_s != ack_s_q)) begin
                spurious_err <= 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (tx_level != '0) begin
                        O_pulpino_data <= fifo_mem[rd_ptr];
                        tx_req         <= ~tx_req;
                        tx_state       <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (ack_s == tx_req) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign O_pulpino_flags = {4'b0000, spurious_err, tx_nonempty, tx_req, rx_ack};

endmodule

// File: tb/tb_cw305_pulpino_mailbox_ctrl.sv
// Self-checking bench for cw305_pulpino_mailbox_ctrl: a directed vector table,
// hand-written corner sequences and a randomised run against a transaction model.
module tb_cw305_pulpino_mailbox_ctrl;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          crypto_clk = 1'b0;
    logic          reset_i;
    logic [7:0]    I_ext_data;
    logic [7:0]    I_ext_flags;
    logic [7:0]    O_pulpino_data;
    logic [7:0]    O_pulpino_flags;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [LW-1:0] tx_level;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic host_req = 1'b0;
    logic host_ack = 1'b0;

    typedef struct {
        logic [7:0] ed;
        logic [7:0] ef;
        logic       rdy;
        logic       tv;
        logic [7:0] td;
        logic       e_rv;
        logic [7:0] e_rd;
        logic [7:0] e_flags;
        logic [7:0] e_pd;
        logic [2:0] e_lvl;
        logic       e_tr;
    } vec_t;

    vec_t vecs [16];

    cw305_pulpino_mailbox_ctrl #(
        .pFIFO_DEPTH  (DEPTH),
        .pSYNC_STAGES (SYNC)
    ) dut (
        .crypto_clk      (crypto_clk),
        .reset_i         (reset_i),
        .I_ext_data      (I_ext_data),
        .I_ext_flags     (I_ext_flags),
        .O_pulpino_data  (O_pulpino_data),
        .O_pulpino_flags (O_pulpino_flags),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_level        (tx_level)
    );

    always #5 crypto_clk = ~crypto_clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        cycle++;
        #1;
    endtask

    task automatic driveFlags();
        I_ext_flags = {6'b000000, host_ack, host_req};
    endtask

    task automatic doReset(input int n);
        reset_i  = 1'b1;
        host_req = 1'b0;
        host_ack = 1'b0;
        driveFlags();
        I_ext_data = 8'h00;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        repeat (n) tick();
        reset_i = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_pdata"},    32'(O_pulpino_data),  32'h00);
        chk({tag, "_flags"},    32'(O_pulpino_flags), 32'h00);
        chk({tag, "_rx_data"},  32'(rx_data),         32'h00);
        chk({tag, "_rx_valid"}, 32'(rx_valid),        32'h0);
        chk({tag, "_tx_ready"}, 32'(tx_ready),        32'h1);
        chk({tag, "_tx_level"}, 32'(tx_level),        32'h0);
    endtask

    function automatic vec_t mk(input logic [7:0] ed, input logic [7:0] ef, input logic rdy,
                                input logic tv, input logic [7:0] td, input logic e_rv,
                                input logic [7:0] e_rd, input logic [7:0] e_flags,
                                input logic [7:0] e_pd, input logic [2:0] e_lvl, input logic e_tr);
        vec_t v;
        v.ed = ed; v.ef = ef; v.rdy = rdy; v.tv = tv; v.td = td;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_flags = e_flags; v.e_pd = e_pd;
        v.e_lvl = e_lvl; v.e_tr = e_tr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        I_ext_data  = v.ed;
        I_ext_flags = v.ef;
        rx_ready    = v.rdy;
        tx_valid    = v.tv;
        tx_data     = v.td;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        chk($sformatf("vec%0d_rx_valid", idx), 32'(rx_valid),        32'(v.e_rv));
        chk($sformatf("vec%0d_rx_data", idx),  32'(rx_data),         32'(v.e_rd));
        chk($sformatf("vec%0d_flags", idx),    32'(O_pulpino_flags), 32'(v.e_flags));
        chk($sformatf("vec%0d_pdata", idx),    32'(O_pulpino_data),  32'(v.e_pd));
        chk($sformatf("vec%0d_tx_level", idx), 32'(tx_level),        32'(v.e_lvl));
        chk($sformatf("vec%0d_tx_ready", idx), 32'(tx_ready),        32'(v.e_tr));
    endtask

    // Host side: wait for a pending TX byte, check it, then toggle the ack
    task automatic hostReadAck(input logic [7:0] exp, input string name);
        int n = 0;
        while ((O_pulpino_flags[1] == host_ack) && (n < 20)) begin
            tick();
            n++;
        end
        if (O_pulpino_flags[1] == host_ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no tx_req toggle, expected one within 20 cycles", name);
        end else begin
            chk(name, 32'(O_pulpino_data), 32'(exp));
        end
        host_ack = ~host_ack;
        driveFlags();
        tick();
    endtask

    initial begin
        int         lvl;
        int         pop_due;
        logic       rx_pending;
        logic       push_ok;
        logic       pop_now;
        logic [7:0] txq [$];
        logic [7:0] rxq [$];

        // Directed table: RX single byte, then TX queue filling up
        vecs[0] = mk(8'hA5, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
        vecs[1] = mk(8'hA5, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
        for (int i = 2; i < 8; i++) begin
            vecs[i] = mk(8'hA5, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        vecs[8]  = mk(8'hA5, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 8'h01, 8'h00, 3'd0, 1'b1);
        vecs[9]  = mk(8'hA5, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 8'h01, 8'h00, 3'd0, 1'b1);
        vecs[10] = mk(8'hA5, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 8'hA5, 8'h05, 8'h00, 3'd1, 1'b1);
        vecs[11] = mk(8'hA5, 8'h01, 1'b0, 1'b1, 8'h22, 1'b0, 8'hA5, 8'h07, 8'h11, 3'd2, 1'b1);
        vecs[12] = mk(8'hA5, 8'h01, 1'b0, 1'b1, 8'h33, 1'b0, 8'hA5, 8'h07, 8'h11, 3'd3, 1'b1);
        vecs[13] = mk(8'hA5, 8'h01, 1'b0, 1'b1, 8'h44, 1'b0, 8'hA5, 8'h07, 8'h11, 3'd4, 1'b0);
        vecs[14] = mk(8'hA5, 8'h01, 1'b0, 1'b1, 8'h55, 1'b0, 8'hA5, 8'h07, 8'h11, 3'd4, 1'b0);
        vecs[15] = mk(8'hA5, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 8'h07, 8'h11, 3'd4, 1'b0);

        doReset(3);
        checkResetState("reset");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput(vecs[i], i);
        end

        // TX drain: host reads the four queued bytes in order
        host_req = 1'b1;
        host_ack = 1'b0;
        tx_valid = 1'b0;
        driveFlags();
        hostReadAck(8'h11, "drain_byte0");
        hostReadAck(8'h22, "drain_byte1");
        hostReadAck(8'h33, "drain_byte2");
        hostReadAck(8'h44, "drain_byte3");
        repeat (5) tick();
        chk("drain_level", 32'(tx_level),        32'd0);
        chk("drain_flags", 32'(O_pulpino_flags), 32'h01);

        // Simultaneous push and pop at level 2
        tx_valid = 1'b1; tx_data = 8'h61; tick();
        tx_data  = 8'h62; tick();
        tx_valid = 1'b0;
        chk("simul_pre_level", 32'(tx_level), 32'd2);
        hostReadAck(8'h61, "simul_byte0");
        tick();
        chk("simul_mid_level", 32'(tx_level), 32'd2);
        tx_valid = 1'b1; tx_data = 8'h63; tick();
        tx_valid = 1'b0;
        chk("simul_level", 32'(tx_level), 32'd2);
        hostReadAck(8'h62, "simul_byte1");
        hostReadAck(8'h63, "simul_byte2");
        repeat (5) tick();
        chk("simul_end_level", 32'(tx_level), 32'd0);

        // Spurious ack while the TX side is idle sets a sticky error
        chk("spur_before", 32'(O_pulpino_flags[3]), 32'h0);
        host_ack = ~host_ack;
        driveFlags();
        repeat (4) tick();
        chk("spur_set", 32'(O_pulpino_flags[3]), 32'h1);
        repeat (5) tick();
        chk("spur_sticky", 32'(O_pulpino_flags[3]), 32'h1);

        // Put RX in HOLD and TX in WAIT, then reset mid-operation
        host_req   = ~host_req;
        I_ext_data = 8'h3C;
        rx_ready   = 1'b0;
        driveFlags();
        tx_valid = 1'b1; tx_data = 8'h71; tick();
        tx_data  = 8'h72; tick();
        tx_valid = 1'b0;
        repeat (3) tick();
        chk("midrst_rx_valid", 32'(rx_valid),           32'h1);
        chk("midrst_rx_data",  32'(rx_data),            32'h3C);
        chk("midrst_pdata",    32'(O_pulpino_data),     32'h72);
        chk("midrst_level",    32'(tx_level),           32'd1);
        chk("midrst_txreq",    32'(O_pulpino_flags[1]), 32'h1);
        doReset(1);
        checkResetState("midrst_after");
        repeat (4) tick();
        chk("midrst_quiet_flags", 32'(O_pulpino_flags), 32'h00);
        chk("midrst_quiet_rxv",   32'(rx_valid),        32'h0);

        // Randomised traffic against a transaction-level model
        doReset(2);
        lvl        = 0;
        pop_due    = -1;
        rx_pending = 1'b0;
        for (int it = 0; it < 1600; it++) begin
            chk("rand_level",    32'(tx_level),           32'(lvl));
            chk("rand_ready",    32'(tx_ready),           32'(lvl != DEPTH));
            chk("rand_nonempty", 32'(O_pulpino_flags[2]), 32'(lvl != 0));
            chk("rand_err",      32'(O_pulpino_flags[3]), 32'h0);

            if ((O_pulpino_flags[1] != host_ack) && ($urandom_range(0, 2) == 0)) begin
                if (txq.size() == 0) begin
                    chk("rand_tx_unexpected", 32'(O_pulpino_data), 32'hFFFF_FFFF);
                end else begin
                    chk("rand_tx_byte", 32'(O_pulpino_data), 32'(txq[0]));
                end
                host_ack = ~host_ack;
                pop_due  = cycle + SYNC + 1;
            end

            if (rx_pending && (O_pulpino_flags[0] == host_req)) begin
                rx_pending = 1'b0;
            end
            if (!rx_pending && (it < 1500) && ($urandom_range(0, 3) == 0)) begin
                I_ext_data = 8'($urandom_range(0, 255));
                host_req   = ~host_req;
                rxq.push_back(I_ext_data);
                rx_pending = 1'b1;
            end
            driveFlags();

            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) begin
                if (rxq.size() == 0) begin
                    chk("rand_rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("rand_rx_byte", 32'(rx_data), 32'(rxq.pop_front()));
                end
            end

            tx_valid = (it < 1300) ? 1'($urandom_range(0, 1)) : 1'b0;
            tx_data  = 8'($urandom_range(0, 255));

            push_ok = tx_valid && (lvl != DEPTH);
            pop_now = (pop_due == cycle + 1);
            if (push_ok) txq.push_back(tx_data);
            if (pop_now) begin
                if (txq.size() != 0) void'(txq.pop_front());
                pop_due = -1;
            end
            lvl = lvl + int'(push_ok) - int'(pop_now);
            tick();
        end
        chk("rand_txq_empty", 32'(txq.size()), 32'd0);
        chk("rand_rxq_empty", 32'(rxq.size()), 32'd0);
        chk("rand_rx_idle",   32'(rx_pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
